// File: rtl/w_update_sequencer_if.sv
// Host/datapath signal bundle for w_update_sequencer.
// slave is the sequencer's view; master is the host/datapath side.
`timescale 1ns/1ps
interface w_update_sequencer_if #(
    parameter int W_WIDTH = 13
);
    logic               req_valid;
    logic [W_WIDTH-1:0] req_w;
    logic               req_ready;
    logic               signal;
    logic               signal_b;
    logic               decoder_done;
    logic               dp_reset;
    logic               dp_load;
    logic [W_WIDTH-1:0] dp_w;
    logic               busy;
    logic               done;
    logic               err_range;
    logic               err_timeout;
    logic               safe_forced;

    modport master (
        output req_valid, req_w, signal, signal_b, decoder_done,
        input  req_ready, dp_reset, dp_load, dp_w, busy, done,
               err_range, err_timeout, safe_forced
    );

    modport slave (
        input  req_valid, req_w, signal, signal_b, decoder_done,
        output req_ready, dp_reset, dp_load, dp_w, busy, done,
               err_range, err_timeout, safe_forced
    );
endinterface

// File: rtl/w_update_sequencer.sv
// Sequences delay-word (W) updates into the PWM datapath: range check, safe-window wait,
// reset pulse, decoder_done wait. Optional macro W_UPDATE_PENDING_SLOT_EN adds a one-entry request slot.
`timescale 1ns/1ps
module w_update_sequencer #(
    parameter int W_WIDTH      = 13,
    parameter int W_MAX        = 6480,
    parameter int W_INIT       = 0,
    parameter int RESET_CYCLES = 3,
    parameter int SAFE_TIMEOUT = 1024,
    parameter int DONE_TIMEOUT = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    w_update_sequencer_if.slave   bus
);
    localparam int                 WL        = W_WIDTH + 1;
    localparam logic [W_WIDTH:0]   W_MAX_L   = WL'(W_MAX);
    localparam logic [W_WIDTH-1:0] W_INIT_L  = W_WIDTH'(W_INIT);
    localparam logic [15:0]        SAFE_LAST = 16'(SAFE_TIMEOUT - 1);
    localparam logic [15:0]        RST_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0]        DONE_LAST = 16'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INIT, IDLE, WAIT_SAFE, ASSERT_RST, WAIT_DONE, REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [W_WIDTH-1:0] w_pend_q, w_pend_d;
    logic [W_WIDTH-1:0] dp_w_q, dp_w_d;
    logic               dp_reset_q, dp_load_q, busy_q, done_q;
    logic               err_range_q, err_range_d;
    logic               err_timeout_q, err_timeout_d;
    logic               safe_forced_q, safe_forced_d;
    logic               sig_s1_q, sig_s2_q, sigb_s1_q, sigb_s2_q;
    logic               safe_s, req_ready, accept, in_range, finish;
`ifdef W_UPDATE_PENDING_SLOT_EN
    logic               slot_vld_q, slot_vld_d;
    logic [W_WIDTH-1:0] slot_w_q, slot_w_d;
`endif

    assign safe_s   = ~sig_s2_q & ~sigb_s2_q;
    assign in_range = {1'b0, bus.req_w} <= W_MAX_L;
    assign accept   = bus.req_valid & req_ready;

`ifdef W_UPDATE_PENDING_SLOT_EN
    assign req_ready = (state_q == IDLE) || (state_q == WAIT_SAFE) ||
                       (state_q == ASSERT_RST) || (state_q == WAIT_DONE);
`else
    assign req_ready = (state_q == IDLE);
`endif

    always_comb begin
        state_d       = state_q;
        w_pend_d      = w_pend_q;
        dp_w_d        = dp_w_q;
        safe_forced_d = safe_forced_q;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;
        finish        = 1'b0;
        if (accept && !in_range) err_range_d = 1'b1;
        if (accept && in_range)  safe_forced_d = 1'b0;
`ifdef W_UPDATE_PENDING_SLOT_EN
        slot_vld_d = slot_vld_q;
        slot_w_d   = slot_w_q;
        // Latest request wins; an older pending value is simply overwritten.
        if (accept && in_range && state_q != IDLE) begin
            slot_vld_d = 1'b1;
            slot_w_d   = bus.req_w;
        end
`endif
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (accept && in_range) begin
                    w_pend_d = bus.req_w;
                    state_d  = WAIT_SAFE;
                end
            end
            WAIT_SAFE: begin
                // The entry cycle is a settling cycle; safe_s is honoured from the second cycle.
                if (cnt_q != 16'd0 && safe_s) begin
                    state_d = ASSERT_RST;
                end else if (cnt_q == SAFE_LAST) begin
                    safe_forced_d = 1'b1;
                    state_d       = ASSERT_RST;
                end
                if (state_d == ASSERT_RST) dp_w_d = w_pend_q;
            end
            ASSERT_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cnt_q != 16'd0 && bus.decoder_done) begin
                    state_d = REPORT;
                end else if (cnt_q == DONE_LAST) begin
                    err_timeout_d = 1'b1;
                    finish        = 1'b1;
                end
            end
            REPORT:  finish = 1'b1;
            default: state_d = INIT;
        endcase
        if (finish) begin
`ifdef W_UPDATE_PENDING_SLOT_EN
            if (slot_vld_d) begin
                state_d    = WAIT_SAFE;
                w_pend_d   = slot_w_d;
                slot_vld_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
        end
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= INIT;
            cnt_q         <= 16'd0;
            dp_reset_q    <= 1'b1;
            dp_load_q     <= 1'b1;
            dp_w_q        <= W_INIT_L;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            safe_forced_q <= 1'b0;
            // Synchronizers come up "unsafe" until real samples arrive.
            sig_s1_q      <= 1'b1;
            sig_s2_q      <= 1'b1;
            sigb_s1_q     <= 1'b1;
            sigb_s2_q     <= 1'b1;
`ifdef W_UPDATE_PENDING_SLOT_EN
            slot_vld_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dp_reset_q    <= (state_d == ASSERT_RST) || (state_d == INIT);
            dp_load_q     <= (state_d == INIT);
            dp_w_q        <= dp_w_d;
            busy_q        <= !((state_d == IDLE) || (state_d == INIT));
            done_q        <= (state_d == REPORT);
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
            safe_forced_q <= safe_forced_d;
            sig_s1_q      <= bus.signal;
            sig_s2_q      <= sig_s1_q;
            sigb_s1_q     <= bus.signal_b;
            sigb_s2_q     <= sigb_s1_q;
`ifdef W_UPDATE_PENDING_SLOT_EN
            slot_vld_q    <= slot_vld_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        w_pend_q <= w_pend_d;
`ifdef W_UPDATE_PENDING_SLOT_EN
        slot_w_q <= slot_w_d;
`endif
    end

    assign bus.req_ready   = req_ready;
    assign bus.dp_reset    = dp_reset_q;
    assign bus.dp_load     = dp_load_q;
    assign bus.dp_w        = dp_w_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_range   = err_range_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.safe_forced = safe_forced_q;
endmodule

// File: tb/tb_w_update_sequencer.sv
// Directed bench for w_update_sequencer: table of W requests plus hand-written
// sequences for safe-window wait/timeout, done timeout, pending requests and mid-update reset.
`timescale 1ns/1ps
module tb_w_update_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    w_update_sequencer_if #(.W_WIDTH(13)) bus ();

    w_update_sequencer #(
        .W_WIDTH(13), .W_MAX(6480), .W_INIT(0), .RESET_CYCLES(3),
        .SAFE_TIMEOUT(1024), .DONE_TIMEOUT(8192)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int done_seen = 0;
    int exp_done = 0;

    always @(posedge clk) if (bus.done === 1'b1) done_seen++;

    typedef struct {
        logic [12:0] w;
        logic        exp_err;
        logic [12:0] exp_dp_w;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Presents one request; returns just after the accepting edge.
    task automatic request(input logic [12:0] w);
        bus.req_valid = 1'b1;
        bus.req_w     = w;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // From WAIT_DONE entry: decoder_done after 10 cycles, then done pulse and return to IDLE.
    task automatic finish_done(input string tag);
        ticks(10);
        bus.decoder_done = 1'b1;
        tick();
        chk({tag, "_done_hi"}, bus.done, 1);
        bus.decoder_done = 1'b0;
        exp_done++;
        tick();
        chk({tag, "_done_lo"}, bus.done, 0);
        chk({tag, "_busy_lo"}, bus.busy, 0);
    endtask

    // From the accepting edge with safe_s already high.
    task automatic follow_update(input logic [12:0] w, input string tag);
        chk({tag, "_busy"}, bus.busy, 1);
        tick();
        chk({tag, "_rst_e1"}, bus.dp_reset, 0);
        tick();
        chk({tag, "_rst_e2"}, bus.dp_reset, 1);
        chk({tag, "_w_e2"}, bus.dp_w, w);
        ticks(2);
        chk({tag, "_rst_e4"}, bus.dp_reset, 1);
        tick();
        chk({tag, "_rst_e5"}, bus.dp_reset, 0);
        finish_done(tag);
    endtask

    initial begin
        int hi;
        vecs[0] = '{13'd6479, 1'b0, 13'd6479};
        vecs[1] = '{13'd6481, 1'b1, 13'd6479};
        vecs[2] = '{13'd6480, 1'b0, 13'd6480};
        vecs[3] = '{13'd8191, 1'b1, 13'd6480};
        vecs[4] = '{13'd0,    1'b0, 13'd0};
        vecs[5] = '{13'd4096, 1'b0, 13'd4096};

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_w = '0;
        bus.signal = 1'b0;
        bus.signal_b = 1'b0;
        bus.decoder_done = 1'b0;

        // Reset and INIT sequence
        ticks(3);
        chk("rst_dp_reset", bus.dp_reset, 1);
        chk("rst_dp_load", bus.dp_load, 1);
        chk("rst_dp_w", bus.dp_w, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_flags", {bus.done, bus.err_range, bus.err_timeout, bus.safe_forced}, 0);
        reset = 1'b0;
        chk("init_dp_reset", bus.dp_reset, 1);
        chk("init_dp_load", bus.dp_load, 1);
        tick();
        chk("idle_dp_reset", bus.dp_reset, 0);
        chk("idle_dp_load", bus.dp_load, 0);
        chk("idle_dp_w", bus.dp_w, 0);
        chk("idle_ready", bus.req_ready, 1);
        ticks(2);

        // Table of requests with safe window open
        for (int i = 0; i < 6; i++) begin
            request(vecs[i].w);
            chk($sformatf("v%0d_err", i), bus.err_range, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                chk($sformatf("v%0d_busy", i), bus.busy, 0);
                tick();
                chk($sformatf("v%0d_err_lo", i), bus.err_range, 0);
                chk($sformatf("v%0d_no_rst", i), bus.dp_reset, 0);
            end else begin
                follow_update(vecs[i].w, $sformatf("v%0d", i));
            end
            chk($sformatf("v%0d_dp_w", i), bus.dp_w, vecs[i].exp_dp_w);
        end

        // signal held high for 50 cycles, then released
        bus.signal = 1'b1;
        ticks(3);
        request(13'd100);
        hi = 0;
        repeat (50) begin
            tick();
            if (bus.dp_reset !== 1'b0) hi++;
        end
        chk("hold_no_rst", hi, 0);
        bus.signal = 1'b0;
        tick();
        chk("rel_rst1", bus.dp_reset, 0);
        tick();
        chk("rel_rst2", bus.dp_reset, 0);
        tick();
        chk("rel_rst3", bus.dp_reset, 1);
        chk("rel_w", bus.dp_w, 100);
        chk("rel_forced", bus.safe_forced, 0);
        ticks(3);
        chk("rel_rst_off", bus.dp_reset, 0);
        finish_done("rel");

        // signal high permanently: forced after SAFE_TIMEOUT
        bus.signal = 1'b1;
        ticks(3);
        request(13'd200);
        hi = 0;
        repeat (1023) begin
            tick();
            if (bus.dp_reset !== 1'b0) hi++;
        end
        chk("force_no_rst", hi, 0);
        tick();
        chk("force_rst", bus.dp_reset, 1);
        chk("force_flag", bus.safe_forced, 1);
        chk("force_w", bus.dp_w, 200);
        ticks(3);
        bus.signal = 1'b0;
        finish_done("force");
        chk("force_sticky", bus.safe_forced, 1);
        ticks(3);

        // decoder_done never arrives: timeout
        request(13'd300);
        chk("to_forced_clr", bus.safe_forced, 0);
        ticks(5);
        ticks(8191);
        chk("to_not_yet", bus.err_timeout, 0);
        chk("to_busy", bus.busy, 1);
        tick();
        chk("to_pulse", bus.err_timeout, 1);
        chk("to_idle", bus.busy, 0);
        chk("to_w", bus.dp_w, 300);
        tick();
        chk("to_pulse_lo", bus.err_timeout, 0);

        // Requests arriving during WAIT_DONE
        request(13'd2000);
        ticks(5);
`ifdef W_UPDATE_PENDING_SLOT_EN
        chk("slot_ready", bus.req_ready, 1);
        request(13'd3000);
        request(13'd1000);
        bus.decoder_done = 1'b1;
        tick();
        chk("slot_done", bus.done, 1);
        bus.decoder_done = 1'b0;
        exp_done++;
        tick();
        chk("slot_busy", bus.busy, 1);
        chk("slot_w_old", bus.dp_w, 2000);
        ticks(2);
        chk("slot_rst", bus.dp_reset, 1);
        chk("slot_w_new", bus.dp_w, 1000);
        ticks(3);
        finish_done("slot");
        chk("slot_empty", bus.busy, 0);
`else
        bus.req_valid = 1'b1;
        bus.req_w = 13'd3000;
        chk("busy_not_ready", bus.req_ready, 0);
        tick();
        bus.req_valid = 1'b0;
        chk("busy_ignored", bus.busy, 1);
        finish_done("busyreq");
        ticks(3);
        chk("busyreq_idle", bus.busy, 0);
        chk("busyreq_no_rst", bus.dp_reset, 0);
        chk("busyreq_w", bus.dp_w, 2000);
`endif

        // Reset in the middle of ASSERT_RST
        request(13'd500);
        ticks(2);
        chk("mid_in_rst", bus.dp_reset, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_dp_w", bus.dp_w, 0);
        chk("mid_dp_reset", bus.dp_reset, 1);
        chk("mid_dp_load", bus.dp_load, 1);
        chk("mid_busy", bus.busy, 0);
        ticks(2);
        reset = 1'b0;
        chk("mid_init_rst", bus.dp_reset, 1);
        tick();
        chk("mid_idle_rst", bus.dp_reset, 0);
        chk("mid_idle_ready", bus.req_ready, 1);
        ticks(20);
        chk("done_count", done_seen, exp_done);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
